// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file widths, write-back request type and helpers
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    // One write-back request as seen by the register file.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // True when two or more bits are set; clearing the lowest set bit
    // leaves something behind only if there was more than one.
    function automatic logic multi_bit(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Ports:
//   i_req   [N_REQ-1:0] request vector
//   i_ptr   [PTR_W-1:0] index with highest priority this cycle
//   o_grant [N_REQ-1:0] one-hot grant, zero when no request
//   o_index [PTR_W-1:0] index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PTR_W-1:0] o_index
);

    logic w_found;
    int   w_j;

    // Search ptr, ptr+1, ... wrapping at N_REQ; first hit wins.
    always_comb begin
        o_grant = '0;
        o_index = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N_REQ) begin
                w_j = w_j - N_REQ;
            end
            if (!w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_index      = PTR_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter in front of the register file
//
// Optional feature: define REGFILE_WB_ZERO_FILTER_EN to accept writes to
// register 0 but suppress the resulting register-file write enable.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req_valid [N]       per-requester write pending
//   req_addr  [N*5]     per-requester destination register, requester i at [5i+4:5i]
//   req_data  [N*32]    per-requester write data, requester i at [32i+31:32i]
//   req_ready [N]       one-hot grant (combinational)
//   hold                blocks new grants while high
//   rf_we/rf_waddr/rf_wdata  register-file write port, one cycle after transfer
//   conflict_cnt [CNT_W] saturating count of cycles with >1 valid request
module regfile_wb_arbiter
    import mips_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*REG_ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*REG_DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          hold,
    output logic                          rf_we,
    output logic [REG_ADDR_W-1:0]         rf_waddr,
    output logic [REG_DATA_W-1:0]         rf_wdata,
    output logic [CNT_W-1:0]              conflict_cnt
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]      r_ptr;
    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic [REG_DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]      r_cnt;

    logic [N_REQ-1:0]      w_req;
    logic [N_REQ-1:0]      w_grant;
    logic [PTR_W-1:0]      w_idx;
    logic [PTR_W-1:0]      w_ptr_next;
    logic                  w_xfer;
    logic                  w_wr;
    logic                  w_conflict;
    wb_req_t               w_sel;

    // Hold masks requests before arbitration so the pointer cannot move.
    assign w_req = hold ? '0 : req_valid;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_index (w_idx)
    );

    assign req_ready = rst ? '0 : w_grant;
    assign w_xfer    = |(req_valid & req_ready);

    always_comb begin
        w_sel      = '0;
        w_sel.addr = req_addr[int'(w_idx)*REG_ADDR_W +: REG_ADDR_W];
        w_sel.data = req_data[int'(w_idx)*REG_DATA_W +: REG_DATA_W];
    end

    assign w_ptr_next = (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
    assign w_conflict = multi_bit(8'(req_valid));

`ifdef REGFILE_WB_ZERO_FILTER_EN
    // Register 0 is hard-wired; the transfer completes but nothing is written.
    assign w_wr = w_xfer && (w_sel.addr != '0);
`else
    assign w_wr = w_xfer;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_we <= w_wr;
            if (w_xfer) begin
                r_ptr   <= w_ptr_next;
                r_waddr <= w_sel.addr;
                r_wdata <= w_sel.data;
            end
            if (w_conflict && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign rf_we        = r_we;
    assign rf_waddr     = r_waddr;
    assign rf_wdata     = r_wdata;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int N_REQ = 3;
    localparam int CNT_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_REQ-1:0]  req_valid;
    logic [N_REQ*5-1:0]  req_addr;
    logic [N_REQ*32-1:0] req_data;
    logic [N_REQ-1:0]  req_ready;
    logic              hold;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic [CNT_W-1:0]  conflict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0]  addr_tab [3];
    logic [31:0] data_tab [3];
    logic [2:0]  order_mask [6];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .N_REQ (N_REQ),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .hold         (hold),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .conflict_cnt (conflict_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_tables();
        req_addr = {addr_tab[2], addr_tab[1], addr_tab[0]};
        req_data = {data_tab[2], data_tab[1], data_tab[0]};
    endtask

    initial begin
        addr_tab[0] = 5'd3;  data_tab[0] = 32'hA0A0_0000;
        addr_tab[1] = 5'd7;  data_tab[1] = 32'hDEAD_BEEF;
        addr_tab[2] = 5'd12; data_tab[2] = 32'hC2C2_2222;
        order_mask[0] = 3'b001; order_mask[1] = 3'b010; order_mask[2] = 3'b100;
        order_mask[3] = 3'b001; order_mask[4] = 3'b010; order_mask[5] = 3'b100;
        load_tables();
        rst = 1'b1; hold = 1'b0; req_valid = 3'b111;

        // Reset state, with requests present that must be ignored
        step(); step();
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_cnt", 64'(conflict_cnt), 64'd0);
        req_valid = 3'b000;
        rst = 1'b0;

        // Single request on requester 1
        req_valid = 3'b010; #1;
        check("single_ready", 64'(req_ready), 64'b010);
        step();
        check("single_we", 64'(rf_we), 64'd1);
        check("single_waddr", 64'(rf_waddr), 64'd7);
        check("single_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        check("single_cnt", 64'(conflict_cnt), 64'd0);

        // Wrap: ptr=2, requests 0 and 1 -> 0 then 1
        req_valid = 3'b011; #1;
        check("wrap_ready0", 64'(req_ready), 64'b001);
        step();
        check("wrap_waddr0", 64'(rf_waddr), 64'd3);
        check("wrap_wdata0", 64'(rf_wdata), 64'hA0A0_0000);
        check("wrap_cnt0", 64'(conflict_cnt), 64'd1);
        check("wrap_ready1", 64'(req_ready), 64'b010);
        step();
        check("wrap_we1", 64'(rf_we), 64'd1);
        check("wrap_waddr1", 64'(rf_waddr), 64'd7);
        check("wrap_cnt1", 64'(conflict_cnt), 64'd2);

        // Idle: outputs hold last values, no write
        req_valid = 3'b000; #1;
        check("idle_ready", 64'(req_ready), 64'd0);
        step();
        check("idle_we", 64'(rf_we), 64'd0);
        check("idle_waddr", 64'(rf_waddr), 64'd7);
        check("idle_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);

        // Hold for 3 cycles with two requests; conflicts still counted
        hold = 1'b1; req_valid = 3'b011;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("hold_ready", 64'(req_ready), 64'd0);
            step();
            check("hold_we", 64'(rf_we), 64'd0);
            check("hold_cnt", 64'(conflict_cnt), 64'(3 + c));
        end
        // ptr still 2 -> index 0 granted the same cycle hold drops
        hold = 1'b0; #1;
        check("unhold_ready", 64'(req_ready), 64'b001);
        step();
        check("unhold_we", 64'(rf_we), 64'd1);
        check("unhold_waddr", 64'(rf_waddr), 64'd3);
        check("unhold_cnt", 64'(conflict_cnt), 64'd6);

        // Reset right after a transfer: pending write dropped
        req_valid = 3'b010; #1;
        check("pre_rst_ready", 64'(req_ready), 64'b010);
        step();
        check("pre_rst_we", 64'(rf_we), 64'd1);
        req_valid = 3'b000;
        rst = 1'b1; #1;
        check("mid_rst_we", 64'(rf_we), 64'd0);
        check("mid_rst_cnt", 64'(conflict_cnt), 64'd0);
        check("mid_rst_waddr", 64'(rf_waddr), 64'd0);
        step();
        rst = 1'b0;
        // ptr back at 0: requests 1,2 -> index 1 (a stale ptr=2 would pick 2)
        req_valid = 3'b110; #1;
        check("post_rst_ready", 64'(req_ready), 64'b010);
        step();
        check("post_rst_waddr", 64'(rf_waddr), 64'd7);
        check("post_rst_cnt", 64'(conflict_cnt), 64'd1);
        req_valid = 3'b000;

        // Fairness after a fresh reset
        rst = 1'b1; step(); rst = 1'b0;
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("fair_ready", 64'(req_ready), 64'(order_mask[c]));
            step();
            check("fair_we", 64'(rf_we), 64'd1);
            check("fair_waddr", 64'(rf_waddr), 64'(addr_tab[c % 3]));
        end
        check("fair_cnt", 64'(conflict_cnt), 64'd6);
        // Saturation of the 3-bit counter at 7
        step();
        check("sat_cnt7", 64'(conflict_cnt), 64'd7);
        step();
        check("sat_cnt_hold", 64'(conflict_cnt), 64'd7);
        check("sat_we", 64'(rf_we), 64'd1);

        // Address 0 write; ptr is now 2 after grants 0,1
        req_valid = 3'b000; #1; step();
        addr_tab[0] = 5'd0; load_tables();
        req_valid = 3'b001; #1;
        check("zero_ready", 64'(req_ready), 64'b001);
        step();
`ifdef REGFILE_WB_ZERO_FILTER_EN
        check("zero_we_filtered", 64'(rf_we), 64'd0);
`else
        check("zero_we", 64'(rf_we), 64'd1);
        check("zero_waddr", 64'(rf_waddr), 64'd0);
        check("zero_wdata", 64'(rf_wdata), 64'hA0A0_0000);
`endif
        // ptr advanced to 1
        req_valid = 3'b011; #1;
        check("zero_ptr_adv", 64'(req_ready), 64'b010);
        step();
        req_valid = 3'b000;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, giving the number of write-back requesters (2..8).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the conflict counter.
REQ-003 The block SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, N_REQ, per-requester write request pending.
REQ-006 The block SHALL have port req_addr, input, N_REQ*5, per-requester destination register; requester i occupies bits [5i+4:5i].
REQ-007 The block SHALL have port req_data, input, N_REQ*32, per-requester write data; requester i occupies bits [32i+31:32i].
REQ-008 The block SHALL have port req_ready, output, N_REQ, one-hot or zero grant to requesters.
REQ-009 The block SHALL have port hold, input, 1, suppresses all new grants while high.
REQ-010 The block SHALL have port rf_we, output, 1, register-file write enable.
REQ-011 The block SHALL have port rf_waddr, output, 5, register-file write address.
REQ-012 The block SHALL have port rf_wdata, output, 32, register-file write data.
REQ-013 The block SHALL have port conflict_cnt, output, CNT_W, count of cycles with more than one valid request.

Function
REQ-014 req_ready SHALL be combinational from req_valid, hold and the round-robin pointer, with at most one bit set per cycle.
REQ-015 When hold=0, the granted index SHALL be the first i with req_valid[i]=1, searching ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1 (modulo N_REQ).
REQ-016 When hold=1 or no req_valid bit is set, req_ready SHALL be all zero and ptr SHALL be unchanged.
REQ-017 A transfer SHALL occur on requester i when req_valid[i] and req_ready[i] are both high at a rising clk edge.
REQ-018 After a transfer on requester i, ptr SHALL become (i+1) mod N_REQ, wrapping from N_REQ-1 to 0.
REQ-019 A transfer at edge t SHALL give rf_we=1 with that requester's address and data on rf_waddr and rf_wdata during cycle t+1; write latency is exactly one cycle.
REQ-020 rf_we SHALL be high only in cycles directly following a transfer; rf_waddr and rf_wdata SHALL hold their last values otherwise.
REQ-021 Back-to-back transfers SHALL produce rf_we high on consecutive cycles with no bubble; throughput is one write per cycle.
REQ-022 Requesters SHALL keep req_valid, req_addr and req_data stable until their transfer; deasserting valid before the grant withdraws the request with no side effect.
REQ-023 conflict_cnt SHALL increment by 1 in every cycle where two or more req_valid bits are high, regardless of hold, and SHALL saturate at 2^CNT_W-1.

Reset
REQ-024 While rst=1, req_ready SHALL be all zero, and ptr, rf_we, rf_waddr, rf_wdata and conflict_cnt SHALL be 0.
REQ-025 rst asserted in the cycle after a transfer SHALL clear rf_we at once, so that pending write is dropped.
REQ-026 The first grant after rst deasserts SHALL search from index 0.

Configuration
REQ-027 Macro REGFILE_WB_ZERO_FILTER_EN, when defined, SHALL accept a transfer with req_addr=0 normally (ready, ptr update) but SHALL keep rf_we=0 in the following cycle.
REQ-028 Without REGFILE_WB_ZERO_FILTER_EN, writes to address 0 SHALL be forwarded like any other address.

Structure
REQ-029 Package mips_pkg SHALL hold REG_ADDR_W=5, REG_DATA_W=32 and the write-back request struct (addr, data).
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter (req, ptr -> one-hot grant, index), parameterised by N_REQ.

Verification
REQ-031 Single request: req_valid=3'b010, addr=7, data=32'hDEAD_BEEF, hold=0 -> req_ready=3'b010 the same cycle; next cycle rf_we=1, rf_waddr=7, rf_wdata=32'hDEAD_BEEF; ptr=2.
REQ-032 Fairness: req_valid=3'b111 held for 6 cycles after reset -> grant order 0,1,2,0,1,2; rf_we high 6 consecutive cycles; conflict_cnt=6.
REQ-033 Wrap: ptr=2, req_valid=3'b011 -> grant index 0, then 1; ptr goes 2->1->2.
REQ-034 Hold: req_valid=3'b001, hold=1 for 3 cycles -> req_ready=0, rf_we=0, ptr unchanged; hold=0 -> grant in the same cycle.
REQ-035 Reset mid-operation: transfer at edge t, rst pulsed during cycle t+1 -> rf_we=0 immediately; conflict_cnt=0; next grant searches from index 0.
REQ-036 Zero filter: with the macro, transfer with addr=0 -> req_ready=1 and ptr advances, rf_we stays 0; without the macro, rf_we=1 and rf_waddr=0.
